// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I pipeline constants and types
// Purpose: constants and state encoding shared by the IF/ID stage and its helpers.
// Contents: NOP_INSTR (addi x0,x0,0), source-register field positions,
//           if_id_state_t FSM encoding.
package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          RS1_LSB   = 15;
  localparam int          RS2_LSB   = 20;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LU    = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } if_id_state_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
// Purpose: flags when the instruction in ID reads the register a load in EX writes.
// Ports:
//   instr_d     in  32  instruction held in IF/ID
//   id_valid    in  1   IF/ID holds a real instruction
//   ex_mem_read in  1   instruction in EX is a load
//   ex_rd       in  5   destination register of instruction in EX
//   lu_hit      out 1   load-use hazard present
module hazard_detect
  import rv32i_pkg::*;
(
  input  logic [31:0] instr_d,
  input  logic        id_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  output logic        lu_hit
);

  logic [4:0] rs1;
  logic [4:0] rs2;

  assign rs1 = instr_d[RS1_LSB +: 5];
  assign rs2 = instr_d[RS2_LSB +: 5];

  // Opcode is deliberately ignored: instructions without rs1/rs2 may stall
  // spuriously, which costs a cycle but never breaks correctness.
  assign lu_hit = id_valid & ex_mem_read & (ex_rd != 5'd0) &
                  ((ex_rd == rs1) | (ex_rd == rs2));

  // Only the register fields participate in the compare.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_d[31:25], instr_d[14:0]};

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with fetch control and hazard handling
// Purpose: captures fetch output into IF/ID and steers fetch (stall/redirect),
//          resolving EX redirects, load-use hazards and decode back-pressure.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_f, instruction   PC and instruction presented by fetch
//   stall, pc_sel,      fetch control: hold PC / load pc_nxt
//   pc_nxt
//   ex_redirect,        taken branch/jump resolved in EX and its target
//   ex_target
//   ex_mem_read, ex_rd  load-in-EX information for load-use detection
//   id_ready            decode accepts IF/ID this cycle
//   id_valid, pc_d,     IF/ID register contents
//   instr_d
//   id_bubble           ID/EX must load a bubble this cycle
//   stall_cnt,          event counters (wrap around)
//   flush_cnt
module if_id_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = NOP_INSTR,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_f,
  input  logic [31:0]      instruction,
  output logic             stall,
  output logic             pc_sel,
  output logic [31:0]      pc_nxt,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [31:0]      pc_d,
  output logic [31:0]      instr_d,
  output logic             id_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  if_id_state_t state_q;
  if_id_state_t state_nxt;

  logic lu_hit;
  logic lu_stall;
  logic do_load;
  logic do_flush;
  logic inc_stall;

  hazard_detect u_hazard_detect (
    .instr_d     (instr_d),
    .id_valid    (id_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .lu_hit      (lu_hit)
  );

  // IF/ID holds the flush NOP in FLUSH, so nothing there can raise a hazard.
  // No suppression is needed in LU: EX then carries the bubble, so a repeated
  // hit can only come from a different load.
  assign lu_stall = lu_hit & (state_q != FLUSH);

  always_comb begin
    stall     = 1'b0;
    pc_sel    = 1'b0;
    pc_nxt    = 32'h0;
    id_bubble = 1'b0;
    do_load   = 1'b0;
    do_flush  = 1'b0;
    inc_stall = 1'b0;
    state_nxt = RUN;

    if (ex_redirect) begin
      // Redirect beats any stall: both wrong-path instructions are dropped.
      pc_sel    = 1'b1;
      pc_nxt    = ex_target;
      do_flush  = 1'b1;
      state_nxt = FLUSH;
    end else if (lu_stall) begin
      stall     = 1'b1;
      id_bubble = 1'b1;
      inc_stall = 1'b1;
      state_nxt = LU;
    end else if (id_valid && !id_ready) begin
      stall     = 1'b1;
      inc_stall = 1'b1;
      state_nxt = HOLD;
    end else begin
      do_load   = 1'b1;
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      id_valid  <= 1'b0;
      pc_d      <= RESET_PC;
      instr_d   <= NOP;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_nxt;
      if (do_flush) begin
        id_valid  <= 1'b0;
        pc_d      <= ex_target;
        instr_d   <= NOP;
        flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (do_load) begin
        id_valid <= 1'b1;
        pc_d     <= pc_f;
        instr_d  <= instruction;
      end
      if (inc_stall) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Decode-side end of the fetch interface. It captures `pc_f`/`instruction` from the fetch stage into the IF/ID pipeline register and drives the fetch control inputs (`stall`, `pc_sel`, `pc_nxt`) back to it. It resolves three conditions into fetch control and IF/ID register behaviour:
- EX-stage redirects (branches/jumps)
- load-use hazards
- decode back-pressure

It also keeps stall and flush event counters. It sits between the fetch stage and the decode/register-file stage of the RV32I pipeline.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, value of `pc_d` at reset.
- `NOP`, 32'h0000_0013 (addi x0,x0,0), instruction inserted for bubbles.
- `CNT_W`, 32, width of event counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_f`  in  32  PC currently presented by fetch.
- `instruction`  in  32  instruction at `pc_f` (combinational read).
- `stall`  out  1  to fetch; 1 holds PC.
- `pc_sel`  out  1  to fetch; 1 loads `pc_nxt` instead of PC+4.
- `pc_nxt`  out  32  redirect target.
- `ex_redirect`  in  1  EX resolved a taken branch/jump this cycle.
- `ex_target`  in  32  redirect target, valid with `ex_redirect`.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_rd`  in  5  destination register of instruction in EX.
- `id_ready`  in  1  decode accepts the IF/ID contents this cycle.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `pc_d`  out  32  registered PC.
- `instr_d`  out  32  registered instruction.
- `id_bubble`  out  1  ID/EX must load a bubble this cycle.
- `stall_cnt`  out  `CNT_W`  cycles with `stall`=1.
- `flush_cnt`  out  `CNT_W`  redirects taken.

## Operation
Fetch contract: PC holds when `stall`=1. Otherwise PC loads `pc_nxt` if `pc_sel`=1, else PC+4. `pc_sel`=1 overrides `stall`.

FSM states:
- `RUN`: normal flow.
- `LU`: load-use bubble cycle.
- `HOLD`: decode back-pressure.
- `FLUSH`: first cycle after a redirect.

Load-use hit: `id_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==instr_d[19:15] | ex_rd==instr_d[24:20])`. The comparison is made regardless of opcode (conservative).

Priority per cycle (highest first); `stall`/`pc_sel`/`pc_nxt`/`id_bubble` are combinational:
- `rst`: see Timing.
- `ex_redirect`:
  - Outputs: `pc_sel`=1, `pc_nxt`=`ex_target`, `stall`=0.
  - IF/ID next: `id_valid`=0, `instr_d`=`NOP`, `pc_d`=`ex_target`.
  - `flush_cnt`++; next state `FLUSH`.
  - This kills both the wrong-path ID instruction and the wrong-path fetch instruction.
- Load-use hit:
  - Outputs: `stall`=1, `id_bubble`=1.
  - IF/ID holds; `stall_cnt`++; next state `LU`.
- `id_valid & !id_ready`:
  - Outputs: `stall`=1, `id_bubble`=0.
  - IF/ID holds; `stall_cnt`++; next state `HOLD`.
- Otherwise: IF/ID loads `{1, pc_f, instruction}`; next state `RUN`.

Rules that apply in every state:
- `LU` does not re-trigger from the same load. `ex_*` then describes the bubble, so the hit clears naturally.
- In `LU`, a new hit against a different load stalls again.
- `pc_sel`=0 and `pc_nxt`=0 whenever `ex_redirect`=0.
- Counters wrap modulo 2^`CNT_W`.

## Timing
- Reset values:
  - `id_valid`=0, `pc_d`=`RESET_PC`, `instr_d`=`NOP`.
  - `stall_cnt`=`flush_cnt`=0, state `RUN`.
  - `stall`=0, `pc_sel`=0, `id_bubble`=0.
- IF→ID latency: 1 cycle.
- Redirect penalty: exactly 2 bubbles (the killed ID instruction and the killed fetch instruction). The target instruction is valid in ID 2 cycles after `ex_redirect`.
- Load-use penalty: 1 cycle.
- Redirect during `LU`/`HOLD`: redirect wins, and the stall is dropped that cycle.
- Reset asserted mid-stall or mid-flush: all state returns to reset values on the next edge, with no residual stall.

## Structure
- Shared package `rv32i_pkg`:
  - `NOP` constant
  - `RS1_LSB`=15, `RS2_LSB`=20
  - state enum `if_id_state_t` {RUN, LU, HOLD, FLUSH}
- One sub-module, `hazard_detect`: the combinational load-use compare. Inputs `instr_d`, `id_valid`, `ex_mem_read`, `ex_rd`; output `lu_hit`.

## Test plan
- Reset, then free run from `pc_f`=0: `id_valid`=1 from cycle 1, `pc_d` follows 0,4,8… one cycle late; `stall`=0 throughout.
- `instr_d`=add x3,x1,x2 with `ex_mem_read`=1, `ex_rd`=1: one cycle with `stall`=1 and `id_bubble`=1, `pc_d` held; `stall_cnt`=1.
- Same case with `ex_rd`=0 → no stall. Same case with `ex_rd`=5 → no stall.
- `ex_redirect`=1, `ex_target`=0x100 at `pc_f`=0x20: `pc_sel`=1, `pc_nxt`=0x100 that cycle; next cycle `id_valid`=0, `instr_d`=`NOP`; then `pc_d`=0x100 valid; `flush_cnt`=1.
- `id_ready`=0 for 3 cycles, then simultaneous load-use hit and `ex_redirect`: IF/ID held 3 cycles with `stall_cnt`=3, then the redirect wins (`stall`=0, `pc_sel`=1).
- `rst` pulsed during `HOLD`: the next cycle shows all reset values; the following cycle loads `pc_f` normally.
